ad_clock_gen: RTL and testbench

Soft clock-management block for the dual-channel ADC front end.
- Monitors the 50 MHz board clock clkin1 using the fast sampling clock clk_tb (500 MHz).
- Declares lock once clkin1 is stable.
- Produces a gated ADC sample clock clkout0, derived from clk_tb by an integer divider.
- Sits between the board clock input and the ADC interface logic. The global-reset primitive (GTP_GRS) is a vendor cell and is not part of this block.

---
 rtl/ad_clock_pkg.sv | 17 +
 rtl/ad_clock_lockdet.sv | 76 +++++++
 rtl/ad_clock_gen.sv | 54 +++++
 tb/tb_ad_clock_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ad_clock_pkg.sv
// Shared defaults for the ADC front-end clock manager.
package ad_clock_pkg;

  localparam int DEF_EXP_PERIOD = 10;  // 20 ns clkin1 period at 2 ns clk_tb
  localparam int DEF_PERIOD_TOL = 1;
  localparam int DEF_LOCK_CNT   = 16;
  localparam int DEF_TIMEOUT    = 32;
  localparam int DEF_OUT_HALF   = 8;

  // Counter width able to hold the timeout value; never narrower than 8 bits.
  function automatic int cnt_w_for(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/ad_clock_lockdet.sv
// Lock detector: synchronizes clkin1, measures its period in clk_tb cycles
// and asserts pll_lock after enough consecutive in-tolerance periods.
module ad_clock_lockdet
  import ad_clock_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int PERIOD_TOL = DEF_PERIOD_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = cnt_w_for(DEF_TIMEOUT)
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic clkin1,
  output logic pll_lock
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [CNT_W:0]   P_LO     = (CNT_W+1)'(EXP_PERIOD - PERIOD_TOL);
  localparam logic [CNT_W:0]   P_HI     = (CNT_W+1)'(EXP_PERIOD + PERIOD_TOL);

  logic             sync_p0, sync_p1, sync_p2;
  logic             seen;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W:0]   per_smp;
  logic [GW-1:0]    good_cnt;
  logic             rise, eval, in_tol, at_tmo, drop;

  // Measured period includes the edge cycle itself; one extra bit keeps
  // TIMEOUT+1 representable so a saturated count reads as out of tolerance.
  assign per_smp = {1'b0, per_cnt} + (CNT_W+1)'(1);
  assign rise    = sync_p1 & ~sync_p2;
  assign eval    = rise & seen;
  assign in_tol  = (per_smp >= P_LO) && (per_smp <= P_HI);
  assign at_tmo  = (per_cnt == TMO);
  assign drop    = pll_lock & (at_tmo | (eval & ~in_tol));

  // Two-flop synchronizer plus an edge-detect flop.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) {sync_p2, sync_p1, sync_p0} <= 3'b000;
    else        {sync_p2, sync_p1, sync_p0} <= {sync_p1, sync_p0, clkin1};
  end

  // Period counter: cleared on each rise, saturating at the timeout.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      seen    <= 1'b0;
    end else if (rise) begin
      per_cnt <= '0;
      seen    <= 1'b1;
    end else if (!at_tmo) begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

  // Consecutive good-period counter; any bad period or loss restarts it.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n)      good_cnt <= '0;
    else if (drop)   good_cnt <= '0;
    else if (eval) begin
      if (!in_tol)                   good_cnt <= '0;
      else if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + GW'(1);
    end
  end

  // Lock flag: set once the streak is complete, cleared on timeout or bad period.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n)        pll_lock <= 1'b0;
    else if (pll_lock) pll_lock <= ~drop;
    else               pll_lock <= (good_cnt == GOOD_MAX);
  end

endmodule

// File: rtl/ad_clock_gen.sv
// Soft clock manager: lock detection on clkin1 and a gated, divided
// ADC sample clock derived from clk_tb.
module ad_clock_gen
  import ad_clock_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int PERIOD_TOL = DEF_PERIOD_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int OUT_HALF   = DEF_OUT_HALF,
  parameter int CNT_W      = cnt_w_for(TIMEOUT)
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic clkin1,
  output logic clkout0,
  output logic pll_lock
);

  localparam int DW = (OUT_HALF > 1) ? $clog2(OUT_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OUT_HALF - 1);

  logic [DW-1:0] div_cnt;

  ad_clock_lockdet #(
    .EXP_PERIOD (EXP_PERIOD),
    .PERIOD_TOL (PERIOD_TOL),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_lockdet (
    .clk_tb   (clk_tb),
    .rst_n    (rst_n),
    .clkin1   (clkin1),
    .pll_lock (pll_lock)
  );

  // Half-period divider; held in its idle state whenever lock is absent.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      clkout0 <= 1'b0;
    end else if (!pll_lock) begin
      div_cnt <= '0;
      clkout0 <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clkout0 <= ~clkout0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_ad_clock_gen.sv
// Bench for ad_clock_gen: directed and random clkin1 period sequences,
// checked against a period-level lock model and a clkout0 timing monitor.
`timescale 1ns/100ps
module tb_ad_clock_gen;

  localparam int EXP   = 10;
  localparam int TOL   = 1;
  localparam int NLOCK = 16;
  localparam int HALF  = 8;

  logic clk_tb = 1'b0;
  logic rst_n  = 1'b0;
  logic clkin1 = 1'b0;
  logic clkout0, pll_lock;

  int total = 0;
  int bad   = 0;

  // period-level reference model
  int   streak   = 0;
  int   last_len = -1;
  logic m_lock   = 1'b0;

  // output-clock monitor state
  int   cyc        = 0;
  int   lock_cyc   = -1;
  int   last_tog   = -1;
  int   lock_rises = 0;
  logic prev_lock  = 1'b0;
  logic prev_clk   = 1'b0;

  ad_clock_gen dut (
    .clk_tb   (clk_tb),
    .rst_n    (rst_n),
    .clkin1   (clkin1),
    .clkout0  (clkout0),
    .pll_lock (pll_lock)
  );

  always #1 clk_tb = ~clk_tb;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply the lock rules to the interval that just ended.
  task automatic model_edge();
    if (last_len >= 0) begin
      if (last_len >= EXP - TOL && last_len <= EXP + TOL) begin
        streak = (streak < NLOCK) ? streak + 1 : NLOCK;
      end else begin
        streak = 0;
        m_lock = 1'b0;
      end
      if (streak == NLOCK) m_lock = 1'b1;
    end
  endtask

  // One clkin1 rising edge followed by an interval of len clk_tb cycles.
  task automatic do_edge(input int len);
    logic pre_exp;
    pre_exp = (last_len >= 40) ? 1'b0 : m_lock;
    clkin1 = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk_tb);
      if (n == len / 2) clkin1 = 1'b0;
      if (n == 2) check("lock_pre", pll_lock, pre_exp);
      if (n == 5) begin
        model_edge();
        check("lock_post", pll_lock, m_lock);
      end
      if (len >= 40 && n == 38) check("timeout_drop", pll_lock, 1'b0);
    end
    last_len = len;
  endtask

  // Asynchronous reset with clkin1 still toggling, then a clean release.
  task automatic do_reset();
    @(negedge clk_tb);
    rst_n = 1'b0;
    #0.2;
    check("rst_async_lock", pll_lock, 1'b0);
    check("rst_async_clk", clkout0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_tb);
      clkin1 = ((i % 10) < 5);
      check("rst_lock", pll_lock, 1'b0);
      check("rst_clk", clkout0, 1'b0);
    end
    clkin1 = 1'b0;
    repeat (4) @(negedge clk_tb);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_tb);
    streak   = 0;
    m_lock   = 1'b0;
    last_len = -1;
  endtask

  // clkout0 must be gated low after unlock and toggle every HALF cycles while locked.
  always @(posedge clk_tb) begin
    #0.5;
    cyc++;
    if (!prev_lock) check("clk_gated", clkout0, 1'b0);
    if (pll_lock && !prev_lock) begin
      lock_rises++;
      lock_cyc = cyc;
      last_tog = -1;
    end
    if (pll_lock && prev_lock && clkout0 !== prev_clk) begin
      if (last_tog < 0) begin
        check("first_rise_lvl", clkout0, 1'b1);
        check_int("first_rise_dly", cyc - lock_cyc, HALF);
      end else begin
        check_int("half_period", cyc - last_tog, HALF);
      end
      last_tog = cyc;
    end
    prev_lock = pll_lock;
    prev_clk  = clkout0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int r;
    int len;

    // reset behaviour
    do_reset();

    // nominal 50 MHz lock and long hold
    base = lock_rises;
    repeat (40) do_edge(10);
    check("nominal_locked", pll_lock, 1'b1);
    repeat (150) do_edge(10);
    check_int("lock_rises", lock_rises - base, 1);
    check("clk_running", (last_tog >= 0) && (cyc - last_tog <= HALF), 1'b1);

    // clock loss, then restart and relock
    do_edge(60);
    check("loss_clk_low", clkout0, 1'b0);
    repeat (20) do_edge(10);
    check("relock", pll_lock, 1'b1);

    // bad frequency never locks
    do_reset();
    repeat (40) do_edge(15);
    check("badfreq_nolock", pll_lock, 1'b0);
    check("badfreq_clk", clkout0, 1'b0);

    // tolerance edge: alternating 9/11 locks; one 13 unlocks
    do_reset();
    for (int i = 0; i < 40; i++) do_edge((i % 2 == 0) ? 9 : 11);
    check("tol_locked", pll_lock, 1'b1);
    do_edge(13);
    do_edge(10);
    check("tol_unlock", pll_lock, 1'b0);
    repeat (20) do_edge(10);

    // randomized period sequence
    do_reset();
    repeat (300) begin
      r = int'($urandom_range(0, 99));
      if (r < 92)      len = int'($urandom_range(9, 11));
      else if (r < 98) len = int'($urandom_range(7, 13));
      else             len = 45;
      do_edge(len);
    end

    // reset asserted while locked
    repeat (20) do_edge(10);
    check("pre_reset_locked", pll_lock, 1'b1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
